alu_cmd_runner: RTL

Sequencing stage placed directly upstream of the combinational 2-bit ALU (function select s[3:0], mode m, operands a/b, 3-bit result). Accepts ALU commands through a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU, registers the ALU result, and presents it downstream through a second valid/ready handshake. This lets a processor-side producer stream operations without tracking the ALU's combinational timing.

---
 rtl/alu_cmd_runner_if.sv | 38 +++
 rtl/alu_cmd_runner.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_cmd_runner_if.sv
// Handshake bundle between a command producer, the runner and the ALU it drives.
// The master side is the producer/consumer environment (which also hosts the ALU).
interface alu_cmd_runner_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_s;
    logic       cmd_m;
    logic [1:0] cmd_a;
    logic [1:0] cmd_b;

    logic [3:0] alu_s;
    logic       alu_m;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [2:0] alu_out;

    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_data;

    modport master (
        output cmd_valid, cmd_s, cmd_m, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_s, alu_m, alu_a, alu_b,
        output alu_out,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_s, cmd_m, cmd_a, cmd_b,
        output cmd_ready,
        output alu_s, alu_m, alu_a, alu_b,
        input  alu_out,
        output res_valid, res_data,
        input  res_ready
    );
endinterface

// File: rtl/alu_cmd_runner.sv
// Buffers ALU commands in a small FIFO, issues them one at a time to a
// combinational ALU and hands each registered result downstream.
module alu_cmd_runner #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_cmd_runner_if.slave bus,
    output logic [CNTW-1:0] res_cnt,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    logic [1:0]    state;
    logic [8:0]    issue_q;
    logic          res_valid_q;
    logic [2:0]    res_data_q;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // cmd_ready looks only at full, so a pop never lets a full FIFO take a word.
    assign push = bus.cmd_valid && !full;
    assign pop  = !empty && ((state == ST_IDLE) ||
                             (state == ST_HOLD && bus.res_ready));

    assign bus.cmd_ready = !full;
    assign busy          = (state != ST_IDLE) || !empty;

    assign {bus.alu_s, bus.alu_m, bus.alu_a, bus.alu_b} = issue_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    // NOTE: storage is not reset; the zeroed count and pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_s, bus.cmd_m, bus.cmd_a, bus.cmd_b};
        end
    end

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            issue_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        issue_q <= head;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_data_q  <= bus.alu_out;
                    res_valid_q <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_cnt     <= res_cnt + CNTW'(1);
                        if (!empty) begin
                            issue_q <= head;
                            state   <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
